// File: rtl/osf_multichannel_if.sv
// Bus bundle for the multichannel oversample filter: tagged ADC input,
// per-channel parameter update port and tagged averaged output.
interface osf_multichannel_if #(
  parameter int unsigned N_CHAN = 8,
  parameter int unsigned W_CHAN = 3,
  parameter int unsigned W_DATA = 18,
  parameter int unsigned W_EP   = 16,
  parameter int unsigned W_OSM  = 4
);
  logic signed [W_DATA-1:0] data_in;
  logic        [W_CHAN-1:0] chan_in;
  logic                     data_valid_in;
  logic        [N_CHAN-1:0] activate_in;
  logic        [W_EP-1:0]   cycle_delay_in;
  logic        [W_OSM-1:0]  osm_in;
  logic        [W_CHAN-1:0] update_chan_in;
  logic                     update_en_in;
  logic                     update_in;
  logic signed [W_DATA-1:0] data_out;
  logic        [W_CHAN-1:0] chan_out;
  logic                     data_valid_out;

  // Source of samples/updates, sink of results.
  modport master (
    output data_in, chan_in, data_valid_in, activate_in, cycle_delay_in,
    output osm_in, update_chan_in, update_en_in, update_in,
    input  data_out, chan_out, data_valid_out
  );

  // The filter itself.
  modport slave (
    input  data_in, chan_in, data_valid_in, activate_in, cycle_delay_in,
    input  osm_in, update_chan_in, update_en_in, update_in,
    output data_out, chan_out, data_valid_out
  );
endinterface

// File: rtl/osf_multichannel.sv
// Time-multiplexed N-channel oversample filter. Each channel runs its own
// settle-delay / accumulate / rounded-average sequence on the words tagged
// with its channel number. Parameter updates land in pending registers and
// are copied to the active set at every block start.
module osf_multichannel #(
  parameter int unsigned N_CHAN    = 8,
  parameter int unsigned W_CHAN    = 3,
  parameter int unsigned W_DATA    = 18,
  parameter int unsigned W_EP      = 16,
  parameter int unsigned W_OSM     = 4,
  parameter int unsigned MAX_OSM   = 10,
  parameter int unsigned OSM_INIT  = 0,
  parameter int unsigned CDLY_INIT = 0
) (
  input logic             clk_in,
  input logic             reset_in,
  osf_multichannel_if.slave bus
);
  localparam int unsigned W_SUM = W_DATA + MAX_OSM;
  localparam int unsigned W_CNT = MAX_OSM + 1;
  localparam int unsigned W_RND = W_SUM + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_SAMPLE} state_t;

  state_t                   r_state     [N_CHAN];
  logic signed [W_SUM-1:0]  r_sum       [N_CHAN];
  logic        [W_CNT-1:0]  r_cnt       [N_CHAN];
  logic        [W_EP-1:0]   r_dcnt      [N_CHAN];
  logic        [W_OSM-1:0]  r_osm       [N_CHAN];
  logic        [W_EP-1:0]   r_cdly      [N_CHAN];
  logic        [W_OSM-1:0]  r_pend_osm  [N_CHAN];
  logic        [W_EP-1:0]   r_pend_cdly [N_CHAN];
  logic signed [W_DATA-1:0] r_data_out;
  logic        [W_CHAN-1:0] r_chan_out;
  logic                     r_data_valid_out;

  logic        [W_OSM-1:0]  w_osm_clamp;
  logic                     w_hit          [N_CHAN];
  logic                     w_upd          [N_CHAN];
  logic        [W_OSM-1:0]  w_pend_osm_nx  [N_CHAN];
  logic        [W_EP-1:0]   w_pend_cdly_nx [N_CHAN];
  logic signed [W_SUM-1:0]  w_sum_add      [N_CHAN];
  logic        [W_CNT-1:0]  w_cnt_add      [N_CHAN];
  logic                     w_done         [N_CHAN];
  logic        [W_RND-1:0]  w_bias         [N_CHAN];
  logic signed [W_RND-1:0]  w_rnd_sum      [N_CHAN];
  logic signed [W_DATA-1:0] w_avg          [N_CHAN];
  logic        [W_EP-1:0]   w_dcnt_add     [N_CHAN];
  logic                     w_dly_end      [N_CHAN];

  // Per-channel word match, pending-parameter forwarding and block arithmetic.
  always_comb begin
    w_osm_clamp = (bus.osm_in > W_OSM'(MAX_OSM)) ? W_OSM'(MAX_OSM) : bus.osm_in;
    for (int c = 0; c < int'(N_CHAN); c++) begin
      w_hit[c]          = bus.data_valid_in && (bus.chan_in == W_CHAN'(c));
      w_upd[c]          = bus.update_in && bus.update_en_in && (bus.update_chan_in == W_CHAN'(c));
      // An update in the same cycle as a block start applies to that new block.
      w_pend_osm_nx[c]  = w_upd[c] ? w_osm_clamp : r_pend_osm[c];
      w_pend_cdly_nx[c] = w_upd[c] ? bus.cycle_delay_in : r_pend_cdly[c];
      w_sum_add[c]      = r_sum[c] + W_SUM'(bus.data_in);
      w_cnt_add[c]      = r_cnt[c] + W_CNT'(1);
      w_done[c]         = (w_cnt_add[c] == (W_CNT'(1) << r_osm[c]));
      w_bias[c]         = (r_osm[c] == '0) ? '0 : (W_RND'(1) << (r_osm[c] - W_OSM'(1)));
      w_rnd_sum[c]      = W_RND'(w_sum_add[c]) + w_bias[c];
      w_avg[c]          = W_DATA'(w_rnd_sum[c] >>> r_osm[c]);
      w_dcnt_add[c]     = r_dcnt[c] + W_EP'(1);
      w_dly_end[c]      = (w_dcnt_add[c] == r_cdly[c]);
    end
  end

  // Per-channel sequencer plus the shared registered output port.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int c = 0; c < int'(N_CHAN); c++) begin
        r_state[c]     <= ST_IDLE;
        r_sum[c]       <= '0;
        r_cnt[c]       <= '0;
        r_dcnt[c]      <= '0;
        r_osm[c]       <= W_OSM'(OSM_INIT);
        r_cdly[c]      <= W_EP'(CDLY_INIT);
        r_pend_osm[c]  <= W_OSM'(OSM_INIT);
        r_pend_cdly[c] <= W_EP'(CDLY_INIT);
      end
      r_data_out       <= '0;
      r_chan_out       <= '0;
      r_data_valid_out <= 1'b0;
    end else begin
      r_data_valid_out <= 1'b0;
      for (int c = 0; c < int'(N_CHAN); c++) begin
        r_pend_osm[c]  <= w_pend_osm_nx[c];
        r_pend_cdly[c] <= w_pend_cdly_nx[c];
        if (!bus.activate_in[c]) begin
          r_state[c] <= ST_IDLE;
          r_sum[c]   <= '0;
          r_cnt[c]   <= '0;
          r_dcnt[c]  <= '0;
        end else begin
          unique case (r_state[c])
            ST_IDLE: begin
              r_state[c] <= ST_SAMPLE;
              r_osm[c]   <= w_pend_osm_nx[c];
              r_cdly[c]  <= w_pend_cdly_nx[c];
            end
            ST_SAMPLE: begin
              if (w_hit[c]) begin
                if (w_done[c]) begin
                  r_data_valid_out <= 1'b1;
                  r_data_out       <= w_avg[c];
                  r_chan_out       <= W_CHAN'(c);
                  r_sum[c]         <= '0;
                  r_cnt[c]         <= '0;
                  if (r_cdly[c] != '0) begin
                    r_state[c] <= ST_DELAY;
                    r_dcnt[c]  <= '0;
                  end else begin
                    r_osm[c]  <= w_pend_osm_nx[c];
                    r_cdly[c] <= w_pend_cdly_nx[c];
                  end
                end else begin
                  r_sum[c] <= w_sum_add[c];
                  r_cnt[c] <= w_cnt_add[c];
                end
              end
            end
            ST_DELAY: begin
              if (w_hit[c]) begin
                if (w_dly_end[c]) begin
                  r_state[c] <= ST_SAMPLE;
                  r_dcnt[c]  <= '0;
                  r_osm[c]   <= w_pend_osm_nx[c];
                  r_cdly[c]  <= w_pend_cdly_nx[c];
                end else begin
                  r_dcnt[c] <= w_dcnt_add[c];
                end
              end
            end
            default: r_state[c] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.chan_out       = r_chan_out;
  assign bus.data_valid_out = r_data_valid_out;
endmodule

// File: tb/tb_osf_multichannel.sv
// Directed plus randomized bench for osf_multichannel against a queue-based
// reference model of the per-channel block averaging.
module tb_osf_multichannel;
  localparam int N_CHAN  = 8;
  localparam int W_CHAN  = 3;
  localparam int W_DATA  = 18;
  localparam int W_EP    = 16;
  localparam int W_OSM   = 4;
  localparam int MAX_OSM = 10;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;

  osf_multichannel_if #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA),
                        .W_EP(W_EP), .W_OSM(W_OSM)) bus ();

  osf_multichannel #(.N_CHAN(N_CHAN), .W_CHAN(W_CHAN), .W_DATA(W_DATA), .W_EP(W_EP),
                     .W_OSM(W_OSM), .MAX_OSM(MAX_OSM), .OSM_INIT(0), .CDLY_INIT(0))
    dut (.clk_in(clk_in), .reset_in(reset_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: collected samples per channel, remaining discards, params.
  bit m_run   [N_CHAN];
  int m_q     [N_CHAN][$];
  int m_dly   [N_CHAN];
  int m_osm   [N_CHAN];
  int m_cdly  [N_CHAN];
  int m_posm  [N_CHAN];
  int m_pcdly [N_CHAN];
  bit exp_dv;
  int exp_data;
  int exp_chan;

  task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CHAN; c++) begin
      m_run[c] = 1'b0; m_q[c].delete(); m_dly[c] = 0;
      m_osm[c] = 0; m_cdly[c] = 0; m_posm[c] = 0; m_pcdly[c] = 0;
    end
    exp_dv = 1'b0; exp_data = 0; exp_chan = 0;
  endfunction

  function automatic void model_start(input int c);
    m_osm[c]  = m_posm[c];
    m_cdly[c] = m_pcdly[c];
  endfunction

  // Rounded mean: floor((sum + ratio/2) / ratio) with ratio = 2**osm.
  function automatic int avg_of(input int c);
    longint s = 0;
    longint d = 1;
    longint num;
    longint q;
    foreach (m_q[c][i]) s += longint'(m_q[c][i]);
    for (int i = 0; i < m_osm[c]; i++) d = d * 2;
    num = s + d / 2;
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic void model_step();
    exp_dv = 1'b0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (bus.update_in && bus.update_en_in && int'(bus.update_chan_in) == c) begin
        m_posm[c]  = (int'(bus.osm_in) > MAX_OSM) ? MAX_OSM : int'(bus.osm_in);
        m_pcdly[c] = int'(bus.cycle_delay_in);
      end
      if (!bus.activate_in[c]) begin
        m_run[c] = 1'b0; m_q[c].delete(); m_dly[c] = 0;
      end else if (!m_run[c]) begin
        m_run[c] = 1'b1;
        model_start(c);
      end else if (bus.data_valid_in && int'(bus.chan_in) == c) begin
        if (m_dly[c] > 0) begin
          m_dly[c]--;
          if (m_dly[c] == 0) model_start(c);
        end else begin
          m_q[c].push_back(int'(bus.data_in));
          if (m_q[c].size() == 2 ** m_osm[c]) begin
            exp_dv = 1'b1; exp_data = avg_of(c); exp_chan = c;
            m_q[c].delete();
            if (m_cdly[c] > 0) m_dly[c] = m_cdly[c];
            else model_start(c);
          end
        end
      end
    end
  endfunction

  // One clock: model consumes the driven inputs, DUT result checked on negedge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    check({tag, ".dv"},   bus.data_valid_out, int'(exp_dv));
    check({tag, ".data"}, bus.data_out,       exp_data);
    check({tag, ".chan"}, bus.chan_out,       exp_chan);
    bus.data_valid_in = 1'b0;
    bus.update_in     = 1'b0;
  endtask

  task automatic send(input int c, input int d, input string tag);
    bus.data_valid_in = 1'b1;
    bus.chan_in       = W_CHAN'(c);
    bus.data_in       = W_DATA'(d);
    tick(tag);
  endtask

  task automatic upd(input int c, input int osm, input int cdly);
    bus.update_in      = 1'b1;
    bus.update_en_in   = 1'b1;
    bus.update_chan_in = W_CHAN'(c);
    bus.osm_in         = W_OSM'(osm);
    bus.cycle_delay_in = W_EP'(cdly);
    tick("upd");
  endtask

  task automatic set_act(input logic [N_CHAN-1:0] a);
    bus.activate_in = a;
    tick("act");
  endtask

  initial begin
    bus.data_in = '0; bus.chan_in = '0; bus.data_valid_in = 1'b0;
    bus.activate_in = '0; bus.cycle_delay_in = '0; bus.osm_in = '0;
    bus.update_chan_in = '0; bus.update_en_in = 1'b1; bus.update_in = 1'b0;
    model_reset();

    @(negedge clk_in);
    @(negedge clk_in);
    check("reset.dv",   bus.data_valid_out, 0);
    check("reset.data", bus.data_out,       0);
    check("reset.chan", bus.chan_out,       0);
    reset_in = 1'b0;

    // ch0 osm=2 cdly=0, ch1 words ignored while inactive
    upd(0, 2, 0);
    set_act(8'b0000_0001);
    send(0, 1, "tp1"); send(1, 100, "tp1"); send(0, 2, "tp1");
    send(1, -50, "tp1"); send(0, 3, "tp1"); send(0, 4, "tp1");
    check("tp1.const", bus.data_out, 3);

    // ch3 osm=1 cdly=2: negative rounding, discarded words
    upd(3, 1, 2);
    set_act(8'b0000_1001);
    send(3, 5, "tp2"); send(3, -6, "tp2");
    check("tp2.neg_round", bus.data_out, 0);
    check("tp2.chan", bus.chan_out, 3);
    send(3, 7, "tp2"); send(3, 8, "tp2");
    check("tp2.discard", bus.data_valid_out, 0);
    send(3, 9, "tp2"); send(3, 10, "tp2");
    check("tp2.second", bus.data_out, 10);

    // ch2 osm 3 -> 0 mid-block
    upd(2, 3, 0);
    set_act(8'b0000_1101);
    send(2, 10, "tp3"); send(2, 20, "tp3"); send(2, 30, "tp3");
    upd(2, 0, 0);
    for (int i = 4; i <= 8; i++) send(2, 10 * i, "tp3");
    check("tp3.avg8", bus.data_out, 45);
    send(2, 7, "tp3");
    send(2, -9, "tp3");
    check("tp3.pass", bus.data_out, -9);

    // ch0/ch1 interleaved with osm=0: a pulse every cycle
    set_act('0);
    upd(0, 0, 0);
    upd(1, 0, 0);
    set_act(8'b0000_0011);
    for (int i = 0; i < 8; i++) begin
      send(i % 2, int'($urandom_range(0, 262143)) - 131072, "tp4");
      check("tp4.every", bus.data_valid_out, 1);
    end

    // full scale at the clamped maximum ratio (osm 15 -> 10)
    set_act('0);
    upd(5, 15, 0);
    set_act(8'b0010_0000);
    for (int i = 0; i < 1024; i++) send(5, 131071, "tp5p");
    check("tp5.max", bus.data_out, 131071);
    for (int i = 0; i < 1024; i++) send(5, -131072, "tp5n");
    check("tp5.min", bus.data_out, -131072);

    // deactivate after 3 of 4 samples, then reactivate
    set_act('0);
    upd(0, 2, 0);
    set_act(8'b0000_0001);
    send(0, 50, "tp6"); send(0, 60, "tp6"); send(0, 70, "tp6");
    set_act('0);
    check("tp6.nopulse", bus.data_valid_out, 0);
    set_act(8'b0000_0001);
    send(0, 100, "tp6"); send(0, 200, "tp6"); send(0, 300, "tp6"); send(0, 400, "tp6");
    check("tp6.fresh", bus.data_out, 250);

    // reset mid-block: immediate clear, params back to initial osm=0
    send(0, 1, "tp7"); send(0, 2, "tp7"); send(0, 3, "tp7");
    reset_in = 1'b1;
    #1;
    model_reset();
    check("rst_mid.dv",   bus.data_valid_out, 0);
    check("rst_mid.data", bus.data_out,       0);
    check("rst_mid.chan", bus.chan_out,       0);
    @(negedge clk_in);
    reset_in = 1'b0;
    tick("tp7");
    send(0, 5, "tp7");
    check("tp7.osm_init", bus.data_out, 5);

    // randomized traffic against the model
    bus.activate_in = 8'hFF;
    tick("rnd");
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        bus.data_valid_in = 1'b1;
        bus.chan_in       = W_CHAN'($urandom_range(0, N_CHAN - 1));
        bus.data_in       = W_DATA'(int'($urandom_range(0, 262143)) - 131072);
      end
      if (r >= 60 && r < 80) begin
        bus.update_in      = 1'b1;
        bus.update_en_in   = ($urandom_range(0, 4) != 0);
        bus.update_chan_in = W_CHAN'($urandom_range(0, N_CHAN - 1));
        bus.osm_in         = ($urandom_range(0, 19) == 0) ? W_OSM'($urandom_range(11, 15))
                                                          : W_OSM'($urandom_range(0, 3));
        bus.cycle_delay_in = W_EP'($urandom_range(0, 3));
      end
      if (r >= 96) begin
        int b;
        b = int'($urandom_range(0, N_CHAN - 1));
        bus.activate_in[b] = ~bus.activate_in[b];
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
